rr_mux_reg: RTL and testbench

- Parametrised N-channel, WIDTH-bit selector: generalises the single-bit two-input select function (z = a&~c | b&c) to NCH channels.
- Adds per-channel valid/ready handshake, an arbitration policy (fixed priority or round-robin) and a registered output stage.
- Sits between multiple producers and one shared consumer on the datapath.

---
 rtl/rr_mux_reg.sv | 92 +++++++++
 tb/tb_rr_mux_reg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NCH-to-1 valid/ready arbiter (fixed or round-robin) with a
// registered output stage. in_ready is one-hot/zero; out_* come from flops.
module rr_mux_reg #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  bit RR    = 1'b1,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic            load_en;
  logic            gnt_any;
  logic            grant;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] start;
  int              idx;

  assign load_en = ~out_valid_q | out_ready;
  assign start   = RR ? ptr_q : '0;

  // First valid channel scanning upward from start, wrapping at NCH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(start) + k) % NCH;
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

  // rst_n gate keeps in_ready low while the stage is held in reset.
  assign grant = load_en & gnt_any & rst_n;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      if (RR) begin
        ptr_d = (int'(gnt_idx) == NCH-1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed checks of rr_mux_reg in round-robin,
// fixed-priority and single-channel builds.
module tb_rr_mux_reg;

  logic clk;
  logic rst_n;

  logic [3:0]  rr_vld, rr_rdy;
  logic [31:0] rr_dat;
  logic        rr_ov, rr_ordy;
  logic [7:0]  rr_od;
  logic [1:0]  rr_os;

  logic [3:0]  fp_vld, fp_rdy;
  logic [31:0] fp_dat;
  logic        fp_ov, fp_ordy;
  logic [7:0]  fp_od;
  logic [1:0]  fp_os;

  logic [0:0]  on_vld, on_rdy;
  logic [7:0]  on_dat;
  logic        on_ov, on_ordy;
  logic [7:0]  on_od;
  logic [0:0]  on_os;

  int n_pass;
  int n_total;

  rr_mux_reg #(.WIDTH(8), .NCH(4), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(rr_vld), .in_data(rr_dat), .in_ready(rr_rdy),
    .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os),
    .out_ready(rr_ordy)
  );

  rr_mux_reg #(.WIDTH(8), .NCH(4), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(fp_vld), .in_data(fp_dat), .in_ready(fp_rdy),
    .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os),
    .out_ready(fp_ordy)
  );

  rr_mux_reg #(.WIDTH(8), .NCH(1), .RR(1'b1)) u_one (
    .clk(clk), .rst_n(rst_n),
    .in_valid(on_vld), .in_data(on_dat), .in_ready(on_rdy),
    .out_valid(on_ov), .out_data(on_od), .out_sel(on_os),
    .out_ready(on_ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    n_total++;
    if ({rr_ov, rr_os, rr_od, rr_rdy} !== 15'h0)
      $display("FAIL reset_out got %h exp 0",
               {rr_ov, rr_os, rr_od, rr_rdy});
    else n_pass++;
    n_total++;
    if ({fp_ov, fp_rdy, on_ov, on_rdy} !== 7'h0)
      $display("FAIL reset_others got %h exp 0",
               {fp_ov, fp_rdy, on_ov, on_rdy});
    else n_pass++;
  endtask

  task automatic test_single();
    rr_vld  = 4'b0100;
    rr_dat  = 32'h00A5_0000;
    rr_ordy = 1'b1;
    #1;
    n_total++;
    if (rr_rdy !== 4'b0100)
      $display("FAIL single_rdy got %b exp 0100", rr_rdy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd2, 8'hA5})
      $display("FAIL single_out got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd2, 8'hA5});
    else n_pass++;
  endtask

  // Pointer is 3 after the single-channel grant, so the scan wraps.
  task automatic test_rr_fair();
    logic [1:0] e;
    logic [3:0] oh;
    rr_vld = 4'b1111;
    rr_dat = 32'h1312_1110;
    for (int c = 0; c < 7; c++) begin
      e  = 2'((3 + c) % 4);
      oh = 4'b0001 << e;
      #1;
      n_total++;
      if (rr_rdy !== oh)
        $display("FAIL fair_rdy[%0d] got %b exp %b", c, rr_rdy, oh);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({rr_ov, rr_os, rr_od} !== {1'b1, e, 8'h10 + {6'd0, e}})
        $display("FAIL fair_out[%0d] got %h exp %h", c,
                 {rr_ov, rr_os, rr_od}, {1'b1, e, 8'h10 + {6'd0, e}});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    rr_vld = 4'b0001;
    rr_dat = 32'h0000_003C;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd0, 8'h3C})
      $display("FAIL bp_load got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd0, 8'h3C});
    else n_pass++;
    rr_ordy = 1'b0;
    rr_vld  = 4'b1111;
    rr_dat  = 32'h1312_213C;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++;
      if (rr_rdy !== 4'b0000)
        $display("FAIL bp_rdy[%0d] got %b exp 0000", c, rr_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd0, 8'h3C})
        $display("FAIL bp_hold[%0d] got %h exp %h", c,
                 {rr_ov, rr_os, rr_od}, {1'b1, 2'd0, 8'h3C});
      else n_pass++;
    end
    rr_ordy = 1'b1;
    #1;
    n_total++;
    if (rr_rdy !== 4'b0010)
      $display("FAIL bp_release_rdy got %b exp 0010", rr_rdy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd1, 8'h21})
      $display("FAIL bp_release got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd1, 8'h21});
    else n_pass++;
    rr_vld = 4'b0001;
    rr_dat = 32'h0000_0011;
    #1;
    n_total++;
    if (rr_rdy !== 4'b0001)
      $display("FAIL bp_ch0_rdy got %b exp 0001", rr_rdy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd0, 8'h11})
      $display("FAIL bp_ch0 got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd0, 8'h11});
    else n_pass++;
  endtask

  task automatic test_drain();
    rr_vld = 4'b0000;
    #1;
    n_total++;
    if (rr_rdy !== 4'b0000)
      $display("FAIL drain_rdy got %b exp 0000", rr_rdy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b0, 2'd0, 8'h11})
      $display("FAIL drain got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b0, 2'd0, 8'h11});
    else n_pass++;
  endtask

  task automatic test_fixed_prio();
    fp_vld  = 4'b1010;
    fp_dat  = 32'h5300_5100;
    fp_ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (fp_rdy !== 4'b0010)
        $display("FAIL fp_rdy[%0d] got %b exp 0010", c, fp_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({fp_ov, fp_os, fp_od} !== {1'b1, 2'd1, 8'h51})
        $display("FAIL fp_out[%0d] got %h exp %h", c,
                 {fp_ov, fp_os, fp_od}, {1'b1, 2'd1, 8'h51});
      else n_pass++;
    end
    fp_vld = 4'b1000;
    @(posedge clk); #1;
    n_total++;
    if ({fp_ov, fp_os, fp_od} !== {1'b1, 2'd3, 8'h53})
      $display("FAIL fp_ch3 got %h exp %h",
               {fp_ov, fp_os, fp_od}, {1'b1, 2'd3, 8'h53});
    else n_pass++;
    fp_vld = 4'b0000;
  endtask

  task automatic test_nch1();
    logic [7:0] v;
    on_vld  = 1'b1;
    on_ordy = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      v      = 8'(c);
      on_dat = v;
      #1;
      n_total++;
      if (on_rdy !== 1'b1)
        $display("FAIL one_rdy[%0d] got %b exp 1", c, on_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({on_ov, on_os, on_od} !== {1'b1, 1'b0, v})
        $display("FAIL one_out[%0d] got %h exp %h", c,
                 {on_ov, on_os, on_od}, {1'b1, 1'b0, v});
      else n_pass++;
    end
    on_vld = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({on_ov, on_od} !== {1'b0, 8'h03})
      $display("FAIL one_drain got %h exp %h",
               {on_ov, on_od}, {1'b0, 8'h03});
    else n_pass++;
  endtask

  // Pointer ends at 3 before reset; after reset ch0 must win again.
  task automatic test_reset_mid();
    rr_vld  = 4'b0100;
    rr_dat  = 32'h00A5_0000;
    rr_ordy = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd2, 8'hA5})
      $display("FAIL rmid_load got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd2, 8'hA5});
    else n_pass++;
    rr_ordy = 1'b0;
    rr_vld  = 4'b1111;
    rr_dat  = 32'h1312_1110;
    #2;
    rr_ordy = 1'b1;
    rst_n   = 1'b0;
    #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od, rr_rdy} !== 15'h0)
      $display("FAIL rmid_async got %h exp 0",
               {rr_ov, rr_os, rr_od, rr_rdy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({rr_ov, rr_os, rr_od} !== {1'b1, 2'd0, 8'h10})
      $display("FAIL rmid_ptr got %h exp %h",
               {rr_ov, rr_os, rr_od}, {1'b1, 2'd0, 8'h10});
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    rr_vld  = 4'b1111;
    rr_dat  = 32'h0;
    rr_ordy = 1'b0;
    fp_vld  = 4'b1111;
    fp_dat  = 32'h0;
    fp_ordy = 1'b0;
    on_vld  = 1'b1;
    on_dat  = 8'h0;
    on_ordy = 1'b0;
    #2;
    test_reset();
    rr_vld = 4'b0000;
    fp_vld = 4'b0000;
    on_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single();
    test_rr_fair();
    test_backpressure();
    test_drain();
    test_fixed_prio();
    test_nch1();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
